// File: rtl/hazard_control_unit_if.sv
// Bundle between the ID stage and the hazard controller:
// hazard/branch inputs in, PC/IF-ID/ID-EX control and perf counters out.
interface hazard_control_unit_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
);
    logic [REG_ADDR_W-1:0] ID_EX_rt;
    logic                  ID_EX_mem_read;
    logic [REG_ADDR_W-1:0] IF_ID_rs;
    logic [REG_ADDR_W-1:0] IF_ID_rt;
    logic                  IF_ID_uses_rt;
    logic [1:0]            branch;
    logic                  equal;
    logic                  pc_write;
    logic                  IF_ID_write;
    logic                  mux_hz_unit;
    logic                  flush;
    logic [CNT_W-1:0]      stall_count;
    logic [CNT_W-1:0]      flush_count;

    modport master (
        output ID_EX_rt, ID_EX_mem_read,
        output IF_ID_rs, IF_ID_rt, IF_ID_uses_rt,
        output branch, equal,
        input  pc_write, IF_ID_write,
        input  mux_hz_unit, flush,
        input  stall_count, flush_count
    );

    modport slave (
        input  ID_EX_rt, ID_EX_mem_read,
        input  IF_ID_rs, IF_ID_rt, IF_ID_uses_rt,
        input  branch, equal,
        output pc_write, IF_ID_write,
        output mux_hz_unit, flush,
        output stall_count, flush_count
    );
endinterface

// File: rtl/hazard_control_unit.sv
// Load-use stall and branch/jump flush controller for the 5-stage
// pipeline, with saturating stall/flush event counters.
module hazard_control_unit #(
    parameter int REG_ADDR_W        = 5,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES      = 1,
    parameter int CNT_W             = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    hazard_control_unit_if.slave hz_if
);
    localparam int MAXC = (LOAD_STALL_CYCLES > FLUSH_CYCLES) ?
                          LOAD_STALL_CYCLES : FLUSH_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    typedef enum logic [1:0] {
        IDLE,
        STALL,
        FLUSH
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    rem_q, rem_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic rs_match;
    logic rt_match;
    logic hz;
    logic tk;
    logic hold;
    logic flush_c;

    assign rs_match = hz_if.IF_ID_rs == hz_if.ID_EX_rt;
    assign rt_match = hz_if.IF_ID_uses_rt &&
                      (hz_if.IF_ID_rt == hz_if.ID_EX_rt);

    // Writes to $zero never produce a real dependency
    assign hz = hz_if.ID_EX_mem_read &&
                (hz_if.ID_EX_rt != ZERO_REG) &&
                (rs_match || rt_match);

    always_comb begin
        tk = 1'b0;
        unique case (hz_if.branch)
            2'b01:   tk = hz_if.equal;
            2'b10:   tk = !hz_if.equal;
            2'b11:   tk = 1'b1;
            default: tk = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        hold        = 1'b0;
        flush_c     = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Stall wins; a dependent branch resolves after it
                if (hz) begin
                    hold = 1'b1;
                    if (stall_cnt_q != '1) begin
                        stall_cnt_d = stall_cnt_q + 1'b1;
                    end
                    if (LOAD_STALL_CYCLES > 1) begin
                        state_d = STALL;
                        rem_d   = CW'(LOAD_STALL_CYCLES - 1);
                    end
                end else if (tk) begin
                    flush_c = 1'b1;
                    if (flush_cnt_q != '1) begin
                        flush_cnt_d = flush_cnt_q + 1'b1;
                    end
                    if (FLUSH_CYCLES > 1) begin
                        state_d = FLUSH;
                        rem_d   = CW'(FLUSH_CYCLES - 1);
                    end
                end
            end
            STALL: begin
                hold  = 1'b1;
                rem_d = rem_q - 1'b1;
                if (rem_q == CW'(1)) begin
                    state_d = IDLE;
                end
            end
            FLUSH: begin
                flush_c = 1'b1;
                rem_d   = rem_q - 1'b1;
                if (rem_q == CW'(1)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                rem_d   = '0;
            end
        endcase

        if (!rst_n) begin
            hold    = 1'b0;
            flush_c = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz_if.pc_write    = !hold;
    assign hz_if.IF_ID_write = !hold;
    assign hz_if.mux_hz_unit = !hold;
    assign hz_if.flush       = flush_c;
    assign hz_if.stall_count = stall_cnt_q;
    assign hz_if.flush_count = flush_cnt_q;
endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
Parametrised, stateful hazard controller for the 5-stage MIPS pipeline. It sits between the ID stage and the PC, IF/ID and ID/EX control-mux logic.
- Detects load-use hazards and holds the front end for a configurable number of stall cycles.
- Resolves branches and jumps in ID and squashes a configurable number of fetched slots.
- Ignores false hazards on register $zero.
- Keeps saturating stall and flush event counters for performance debug.

Parameters:
REG_ADDR_W, 5, register specifier width
LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (>=1)
FLUSH_CYCLES, 1, cycles flush is held per taken branch/jump (>=1)
CNT_W, 16, width of performance counters

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
ID_EX_rt  in  REG_ADDR_W  destination of instruction in EX
ID_EX_mem_read  in  1  EX instruction is a load
IF_ID_rs  in  REG_ADDR_W  rs of instruction in ID
IF_ID_rt  in  REG_ADDR_W  rt of instruction in ID
IF_ID_uses_rt  in  1  ID instruction actually reads rt (0 for I-type ALU, lw)
branch  in  2  00 none, 01 beq, 10 bne, 11 jump
equal  in  1  ID register comparator result
pc_write  out  1  1 = PC may update
IF_ID_write  out  1  1 = IF/ID may load
mux_hz_unit  out  1  1 = pass ID control, 0 = insert bubble into ID/EX
flush  out  1  1 = squash IF/ID contents
stall_count  out  CNT_W  number of hazard detections, saturating
flush_count  out  CNT_W  number of taken branches/jumps, saturating

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, remaining-cycle counter=0, stall_count=0, flush_count=0.
  - Outputs while in reset: pc_write=1, IF_ID_write=1, mux_hz_unit=1, flush=0, regardless of the other inputs.
- Hazard condition (combinational):
  - hz = ID_EX_mem_read && ID_EX_rt!=0 && (IF_ID_rs==ID_EX_rt || (IF_ID_uses_rt && IF_ID_rt==ID_EX_rt)).
- Taken condition (combinational):
  - tk = (branch==01 && equal) || (branch==10 && !equal) || branch==11.
- FSM states: IDLE, STALL, FLUSH.
- IDLE:
  - If hz: pc_write=IF_ID_write=mux_hz_unit=0 in the same cycle (zero latency); flush=0; stall_count++.
    - LOAD_STALL_CYCLES>1: next state=STALL, counter=LOAD_STALL_CYCLES-1.
    - Otherwise stay in IDLE.
  - Else if tk: flush=1 in the same cycle; stall outputs stay 1; flush_count++.
    - FLUSH_CYCLES>1: next state=FLUSH, counter=FLUSH_CYCLES-1.
  - Else: all enables 1, flush=0.
  - hz has priority over tk. A branch that depends on a load is re-evaluated after the stall ends.
- STALL:
  - pc_write=IF_ID_write=mux_hz_unit=0; flush=0; inputs are ignored.
  - counter decrements each cycle; at counter==1 the next state is IDLE.
  - New hazards are re-detected only after returning to IDLE; no counter increment while in STALL.
- FLUSH:
  - flush=1; enables=1; hz and tk are ignored because the fetched slots are squashed.
  - counter decrements; at counter==1 the next state is IDLE.
- Counters:
  - Increment once per detection event, not per stall/flush cycle.
  - Saturate at 2^CNT_W-1, with no wrap.
- Reset asserted mid-STALL or mid-FLUSH: immediate return to the reset values above; no residual stall or flush after rst_n deasserts.
- branch==00 with equal toggling: no flush.
- Outputs are a function of state, counter and the current inputs only; no combinational loops through the counters.

Test Plan:
- Defaults; ID_EX_mem_read=1, ID_EX_rt=8, IF_ID_rs=8 -> pc_write/IF_ID_write/mux_hz_unit=0 for exactly 1 cycle; stall_count=1.
- LOAD_STALL_CYCLES=3; same hazard, with mem_read dropped after the first cycle -> enables low for exactly 3 consecutive cycles, then 1; stall_count=1.
- ID_EX_rt=0, IF_ID_rs=0, mem_read=1 -> no stall. IF_ID_rt=8, IF_ID_uses_rt=0, ID_EX_rt=8 -> no stall.
- FLUSH_CYCLES=2; branch=01, equal=1 -> flush high 2 cycles, flush_count=1. branch=10, equal=1 -> no flush. branch=11 -> flush.
- Hazard and branch=11 in the same cycle -> stall only, flush=0. After the stall, with branch still 11 -> flush asserts.
- CNT_W=2; 5 separated hazards -> stall_count saturates at 3. rst_n pulsed low mid-STALL -> enables=1 immediately, counters=0.
